// File: rtl/bq_cascade.sv
// bq_cascade: cascade of NSECT direct-form-I biquads sharing one MAC, with a wishbone register file.
// Define BQ_SAT_EN to clamp section results to the sample range and count clamps in CTRL.OVF.
module bq_cascade #(
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16,
    parameter int NSECT     = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_we_i,
    input  logic [31:0]                 wb_adr_i,
    input  logic [31:0]                 wb_dat_i,
    input  logic [3:0]                  wb_sel_i,
    output logic [31:0]                 wb_dat_o,
    output logic                        wb_ack_o,
    input  logic signed [DATAWIDTH-1:0] x,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic signed [DATAWIDTH-1:0] y,
    output logic                        y_valid_o
);
    localparam int PW = DATAWIDTH + COEFWIDTH;
    localparam int AW = PW + 3;
    localparam logic signed [AW-1:0] HALF = AW'(1) << (COEFWIDTH - 2);

    typedef enum logic [1:0] {IDLE, MAC, UPD, OUT} state_t;

    state_t                      state_q;
    logic [2:0]                  sec_q, tap_q;
    logic signed [DATAWIDTH-1:0] u_q, y_q;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic signed [COEFWIDTH-1:0] shd_q [8][5];
    logic signed [COEFWIDTH-1:0] act_q [8][5];
    logic signed [DATAWIDTH-1:0] u1_q [8];
    logic signed [DATAWIDTH-1:0] u2_q [8];
    logic signed [DATAWIDTH-1:0] y1_q [8];
    logic signed [DATAWIDTH-1:0] y2_q [8];
    logic                        commit_q, clear_q, ack_q, yv_q;
    logic [15:0]                 ovf_q;
    logic [31:0]                 dat_q, rd;

    logic [5:0] word;
    logic [2:0] ws, wk;
    logic       bus_go, wr, coef_hit, ctrl_hit, idle;
    assign word     = wb_adr_i[7:2];
    assign ws       = word[5:3];
    assign wk       = word[2:0];
    assign bus_go   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr       = bus_go & wb_we_i;
    assign coef_hit = (int'(ws) < NSECT) && (wk < 3'd5);
    assign ctrl_hit = word == 6'h3F;
    assign idle     = state_q == IDLE;

    always_comb begin
        rd = coef_hit ? {{(32-COEFWIDTH){shd_q[ws][wk][COEFWIDTH-1]}}, shd_q[ws][wk]} :
             ctrl_hit ? {ovf_q, 13'd0, ~idle, clear_q, commit_q} : 32'd0;
    end

    // Tap order follows the register map: a11, a12, b10, b11, b12.
    logic signed [COEFWIDTH-1:0] c;
    logic signed [DATAWIDTH-1:0] d;
    logic signed [PW-1:0]        prod;
    logic signed [AW-1:0]        prod_x, rsum, rnd;
    always_comb begin
        c = act_q[sec_q][tap_q];
        d = tap_q == 3'd0 ? y1_q[sec_q] : tap_q == 3'd1 ? y2_q[sec_q] : tap_q == 3'd2 ? u_q :
            tap_q == 3'd3 ? u1_q[sec_q] : u2_q[sec_q];
        prod   = PW'(c) * PW'(d);
        prod_x = AW'(prod);
        acc_d  = (tap_q == 3'd0 ? '0 : acc_q) + prod_x;
        rsum   = acc_q + HALF;
        rnd    = rsum >>> (COEFWIDTH - 1);
    end

    logic                        ovf;
    logic signed [DATAWIDTH-1:0] res;
    logic                        unused_ok;
`ifdef BQ_SAT_EN
    localparam logic signed [AW-1:0] MAXV = (AW'(1) << (DATAWIDTH - 1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    assign ovf = (rnd > MAXV) || (rnd < MINV);
    assign res = rnd > MAXV ? MAXV[DATAWIDTH-1:0] : rnd < MINV ? MINV[DATAWIDTH-1:0] : rnd[DATAWIDTH-1:0];
    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:COEFWIDTH]};
`else
    assign ovf = 1'b0;
    assign res = rnd[DATAWIDTH-1:0];
    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:COEFWIDTH], rnd[AW-1:DATAWIDTH]};
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            sec_q    <= '0;
            tap_q    <= '0;
            u_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            commit_q <= 1'b0;
            clear_q  <= 1'b0;
            ack_q    <= 1'b0;
            yv_q     <= 1'b0;
            ovf_q    <= '0;
            dat_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                u1_q[i] <= '0;
                u2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
                for (int j = 0; j < 5; j++) begin
                    shd_q[i][j] <= '0;
                    act_q[i][j] <= '0;
                end
            end
        end else begin
            ack_q <= bus_go;
            if (bus_go) dat_q <= rd;
            if (wr && coef_hit) shd_q[ws][wk] <= wb_dat_i[COEFWIDTH-1:0];
            // A fresh write in the applying cycle stays pending for the next IDLE pass.
            commit_q <= (commit_q & ~idle) | (wr & ctrl_hit & wb_dat_i[0]);
            clear_q  <= (clear_q & ~idle) | (wr & ctrl_hit & wb_dat_i[1]);
            yv_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (commit_q | clear_q) begin
                        if (commit_q) act_q <= shd_q;
                        if (clear_q) begin
                            for (int i = 0; i < 8; i++) begin
                                u1_q[i] <= '0;
                                u2_q[i] <= '0;
                                y1_q[i] <= '0;
                                y2_q[i] <= '0;
                            end
                        end
                    end else if (valid_i) begin
                        u_q     <= x;
                        sec_q   <= '0;
                        tap_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    tap_q <= tap_q + 3'd1;
                    if (tap_q == 3'd4) state_q <= UPD;
                end
                UPD: begin
                    u2_q[sec_q] <= u1_q[sec_q];
                    u1_q[sec_q] <= u_q;
                    y2_q[sec_q] <= y1_q[sec_q];
                    y1_q[sec_q] <= res;
                    u_q         <= res;
                    tap_q       <= '0;
                    if (ovf && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
                    if (int'(sec_q) == NSECT - 1) state_q <= OUT;
                    else begin
                        sec_q   <= sec_q + 3'd1;
                        state_q <= MAC;
                    end
                end
                OUT: begin
                    y_q     <= u_q;
                    yv_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o   = idle & ~commit_q & ~clear_q;
    assign y         = y_q;
    assign y_valid_o = yv_q;
    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
endmodule

// File: tb/tb_bq_cascade.sv
// tb_bq_cascade: randomized bench for bq_cascade against an arithmetic per-section biquad model.
module tb_bq_cascade;
    localparam int NS  = 2;
    localparam int LAT = 6 * NS + 1;
`ifdef BQ_SAT_EN
    localparam int SAT_OVF = 1;
`else
    localparam int SAT_OVF = 0;
`endif

    logic               clk = 0, rst = 1;
    logic               cyc = 0, stb = 0, we = 0, ack;
    logic [31:0]        adr = 0, wdat = 0, rdat;
    logic [3:0]         sel = 4'hF;
    logic signed [15:0] x = 0, y;
    logic               valid = 0, ready, yv;

    int n_chk = 0, n_fail = 0, cyc_n = 0, last_acc = 0;
    int ys[$], yt[$], ex[$], et[$];
    longint msh[8][5], mact[8][5], mu1[8], mu2[8], my1[8], my2[8];
    int m_ovf = 0;
    bit m_commit = 0, m_clear = 0;

    bq_cascade #(.DATAWIDTH(16), .COEFWIDTH(16), .NSECT(NS)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(rdat), .wb_ack_o(ack),
        .x(x), .valid_i(valid), .ready_o(ready), .y(y), .y_valid_o(yv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(posedge clk) begin
        #1;
        if (yv) begin
            ys.push_back(int'(y));
            yt.push_back(cyc_n);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic void model_reset();
        foreach (mu1[i]) begin
            mu1[i] = 0; mu2[i] = 0; my1[i] = 0; my2[i] = 0;
            for (int k = 0; k < 5; k++) begin msh[i][k] = 0; mact[i][k] = 0; end
        end
        m_ovf = 0; m_commit = 0; m_clear = 0;
    endfunction

    function automatic void apply_pending();
        if (m_commit) mact = msh;
        if (m_clear) foreach (mu1[i]) begin mu1[i] = 0; mu2[i] = 0; my1[i] = 0; my2[i] = 0; end
        m_commit = 0;
        m_clear  = 0;
    endfunction

    function automatic int model(input int xv);
        longint u = xv, acc, r;
        for (int s = 0; s < NS; s++) begin
            acc = mact[s][0] * my1[s] + mact[s][1] * my2[s] + mact[s][2] * u
                + mact[s][3] * mu1[s] + mact[s][4] * mu2[s];
            r = (acc + 16384) >>> 15;
`ifdef BQ_SAT_EN
            if (r > 32767 || r < -32768) begin
                r = r > 32767 ? 32767 : -32768;
                if (m_ovf < 65535) m_ovf++;
            end
`else
            r = r & 64'hFFFF;
            if (r > 32767) r -= 65536;
`endif
            mu2[s] = mu1[s]; mu1[s] = u; my2[s] = my1[s]; my1[s] = r; u = r;
        end
        return int'(u);
    endfunction

    task automatic xfer(input bit w, input int word, input logic [31:0] d, output logic [31:0] q);
        int k = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = 32'(word) << 2; wdat = d;
        @(posedge clk); #1;
        while (!ack && k < 8) begin @(posedge clk); #1; k++; end
        if (!ack) chk("wb_ack_timeout", 0, 1);
        q = rdat;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input int word, input logic [31:0] d);
        logic [31:0] q;
        xfer(1, word, d, q);
    endtask

    task automatic rd(input int word, output logic [31:0] q);
        xfer(0, word, 32'd0, q);
    endtask

    task automatic coef(input int s, input int k, input logic [15:0] v);
        wr(s * 8 + k, {16'($urandom), v});
        msh[s][k] = longint'($signed(v));
    endtask

    task automatic ctrl(input bit cm, input bit cl);
        wr(63, {30'd0, cl, cm});
        m_commit |= cm;
        m_clear  |= cl;
    endtask

    task automatic put(input int xv, input bit keep);
        int k = 0;
        @(negedge clk);
        x = 16'(xv); valid = 1;
        while (!ready && k < 200) begin @(negedge clk); k++; end
        if (!ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        last_acc = cyc_n;
        @(negedge clk);
        valid = 0;
        apply_pending();
        if (keep) begin
            ex.push_back(model(xv));
            et.push_back(last_acc);
        end
    endtask

    task automatic get(input string tag);
        int k = 0;
        while (ys.size() == 0 && k < 100) begin @(negedge clk); k++; end
        if (ys.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
            void'(ex.pop_front());
            void'(et.pop_front());
        end else begin
            chk(tag, ys.pop_front(), ex.pop_front());
            chk({tag, "_lat"}, yt.pop_front() - et.pop_front(), LAT);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        bit ok;
        int ta;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_y", y, 0);
        chk("rst_yvalid", yv, 0);
        chk("rst_ready", ready, 1);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        rst = 0;

        coef(0, 2, 16'h4000); coef(1, 2, 16'h7FFF); ctrl(1, 0);
        put(1000, 1);
        ok = 1;
        for (int i = 0; i < LAT; i++) begin
            if (ready) ok = 0;
            @(negedge clk);
        end
        chk("gain_busy_ready_low", ok, 1);
        chk("gain_ready_back", ready, 1);
        get("gain");
        chk("gain_y500", y, 500);

        put(1000, 1); coef(0, 2, 16'h7FFF); get("shadow_cur");
        chk("shadow_cur_y", y, 500);
        put(1000, 1); ctrl(1, 0); rd(63, q);
        chk("ctrl_pending_busy", q[2:0], 3'b101);
        get("shadow_next");
        chk("shadow_next_y", y, 500);
        put(1000, 1); get("shadow_new");
        chk("shadow_new_y", y, 1000);

        coef(1, 4, 16'h8000); rd(12, q);
        chk("rb_sign_ext", q, 32'hFFFF8000);
        rd(2, q);
        chk("rb_b10", q, 32'h00007FFF);
        wr(5, 32'hDEADBEEF); rd(5, q);
        chk("unmapped_rd", q, 0);

        coef(0, 0, 16'h4000); coef(0, 2, 16'h4000); coef(1, 2, 16'h7FFF); coef(1, 4, 16'h0000);
        ctrl(1, 1);
        for (int i = 0; i < 3; i++) begin
            put(i == 0 ? 16384 : 0, 1); get("impulse");
            chk("impulse_const", y, 8192 >> i);
        end

        coef(0, 0, 0); coef(0, 2, 16'h7FFF); coef(0, 3, 16'h7FFF); ctrl(1, 1);
        put(32767, 1); get("sat1");
        put(32767, 1); get("sat2");
        rd(63, q);
        chk("ovf_model", q[31:16], m_ovf);
        chk("ovf_build", q[31:16], SAT_OVF);

        put(100, 1); ta = last_acc; put(200, 1);
        chk("held_valid_gap", last_acc - ta, LAT + 1);
        get("held1"); get("held2");

        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < NS; s++)
                for (int k = 0; k < 5; k++) coef(s, k, 16'($urandom));
            ctrl(1, r == 0);
            for (int i = 0; i < 6; i++) begin
                put(int'($urandom_range(0, 65535)) - 32768, 1);
                get("rand");
            end
        end

        coef(0, 0, 16'h4000); coef(0, 1, 0); coef(0, 2, 16'h4000); coef(0, 3, 0); coef(0, 4, 0);
        coef(1, 0, 0); coef(1, 1, 0); coef(1, 2, 16'h7FFF); coef(1, 3, 0); coef(1, 4, 0);
        ctrl(1, 0);
        for (int i = 0; i < 3; i++) begin put(int'($urandom_range(0, 65535)) - 32768, 1); get("junk"); end
        ctrl(0, 1); rd(63, q);
        chk("clear_selfclear", q[2:0], 0);
        for (int i = 0; i < 3; i++) begin
            put(i == 0 ? 16384 : 0, 1); get("clear_impulse");
            chk("clear_impulse_const", y, 8192 >> i);
        end

        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'(5) << 2;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("b2b_ack", ack, (i % 2) == 0);
        end
        @(negedge clk);
        cyc = 0; stb = 0;

        put(1234, 0);
        @(negedge clk); @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstmid_ready", ready, 1);
        repeat (20) @(negedge clk);
        chk("rstmid_no_yvalid", ys.size(), 0);
        rd(2, q);
        chk("rstmid_coef", q, 0);
        rd(63, q);
        chk("rstmid_ctrl", q, 0);
        model_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bq_cascade.md
# bq_cascade

Parametrised cascade of NSECT direct-form-I biquad sections sharing one time-multiplexed multiply-accumulate unit, with a wishbone coefficient/control register file. It is the successor to the single-section biquad core. It adds a configurable section count, a valid/ready sample handshake and double-buffered (shadow/active) coefficients that can be swapped atomically. Optional output saturation is provided, with an overflow counter. It sits between the sample source and the IoT node output port on the wishbone clock domain.

## Interface
- DATAWIDTH, 16, sample width (two's complement integer)
- COEFWIDTH, 16, coefficient width, Q1.(COEFWIDTH-1) fractional
- NSECT, 2, number of cascaded sections, 1..8
- wb_clk_i  in  1  the only clock; filter and bus logic both run on it
- wb_rst_i  in  1  synchronous active-high reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  wishbone cycle/strobe/write
- wb_adr_i  in  32  byte address; word index = wb_adr_i[7:2]
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  ignored; full-word accesses only
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  wishbone ack
- x  in  DATAWIDTH  input sample
- valid_i  in  1  x is valid
- ready_o  out  1  block can accept a sample
- y  out  DATAWIDTH  filtered output, held until the next result
- y_valid_o  out  1  one-cycle pulse, y updated

## Operation
- Register map (word index):
  - s*8+k is section s coefficient k, with k = 0 a11, 1 a12, 2 b10, 3 b11, 4 b12.
  - Word 0x3F is CTRL.
  - All other words read 0 and ignore writes.
- Coefficient writes store wb_dat_i[COEFWIDTH-1:0] into the shadow bank. Reads return the shadow value sign-extended to 32 bits.
- CTRL bits:
  - [0] COMMIT, write 1: copy shadow to active bank.
  - [1] CLEAR, write 1: zero all delay lines.
  - [2] BUSY, read-only.
  - [31:16] OVF, read-only overflow count.
  - COMMIT and CLEAR read as their pending state and self-clear when applied.
- Per section: y_s = b10·u + b11·u1 + b12·u2 + a11·y1 + a12·y2. Here u is the section input (x for section 0, otherwise y of section s-1), and u1, u2, y1, y2 are that section's delay registers.
- State machine:
  - IDLE: ready_o=1. Pending COMMIT/CLEAR are applied here first; in that cycle ready_o=0 and the sample is not accepted. Otherwise valid_i&ready_o latches x and moves to MAC with s=0, tap=0.
  - MAC: one product per cycle, tap 0..4, accumulated into a DATAWIDTH+COEFWIDTH+3-bit signed accumulator. After tap 4 go to UPD.
  - UPD: round, add 2^(COEFWIDTH-2) then arithmetic shift right by COEFWIDTH-1. Limit to DATAWIDTH. Shift the delay lines (u2←u1, u1←u, y2←y1, y1←result). Result becomes the next section input. If s=NSECT-1 go to OUT, else s+1 and MAC.
  - OUT: register y, pulse y_valid_o, return to IDLE.
- Wishbone: wb_ack_o = registered (cyc&stb&~ack), so it is high for exactly one cycle, one cycle after the strobe. Register writes are accepted in any state. The active bank changes only in IDLE.

## Timing
- Reset values: y=0, y_valid_o=0, ready_o=1 (state IDLE), wb_ack_o=0, wb_dat_o=0. Both coefficient banks, all delay lines, OVF and pending bits are 0.
- Latency: sample accepted at edge n gives y_valid_o at edge n+6·NSECT+1. Throughput is one sample per 6·NSECT+2 cycles.
- valid_i while ready_o=0 is ignored. The source must hold valid_i until it sees ready_o&valid_i.
- COMMIT or CLEAR written while busy stays pending until the next IDLE. A write in the same cycle as a transition to IDLE is applied in the following cycle.
- wb_rst_i mid-computation aborts the computation. No y_valid_o is produced, and all state returns to reset values next cycle.
- OVF saturates at 0xFFFF and does not wrap.

## Configuration
- BQ_SAT_EN defined:
  - A UPD result outside [−2^(DATAWIDTH−1), 2^(DATAWIDTH−1)−1] is clamped to the nearest bound.
  - OVF increments by 1 per clamped section result.
- BQ_SAT_EN undefined:
  - The result is truncated to the low DATAWIDTH bits, so it wraps.
  - OVF reads 0 permanently.

## Test plan
- Gain: NSECT=1. Write b10=0x4000, others 0, then COMMIT. Send x=1000 → y=500 with y_valid_o exactly 7 cycles after acceptance, and ready_o low in between.
- Impulse: NSECT=2. Section 0 b10=0x4000, a11=0x4000; section 1 b10=0x7FFF. Send x=16384, 0, 0 → y = 8192, 4096, 2048 (rounding ±1 LSB).
- Saturation (BQ_SAT_EN): b10=b11=0x7FFF. Send x=0x7FFF twice → second y=0x7FFF and OVF=1. Without the macro → the wrapped value and OVF=0.
- Shadow commit: write new b10 while busy → current and next output use the old value until COMMIT. COMMIT while busy applies only after y_valid_o. Readback returns the sign-extended shadow, e.g. 0x8000 reads 0xFFFF8000.
- CLEAR and reset: load nonzero state, then CLEAR → next impulse response is identical to post-reset. Assert wb_rst_i in MAC → no y_valid_o, ready_o=1 next cycle, coefficients read 0.
- Bus: unmapped word 0x05 reads 0 with ack. Back-to-back strobes → ack alternates 1-cycle pulses. valid_i held during BUSY is accepted only on return to IDLE.
